// File: rtl/serialtopar_rx_pkg.sv
// Shared PHY receive definitions: the comma/idle symbol used by the TX side and the
// alignment FSM state encoding.
package serialtopar_rx_pkg;

   localparam int         SYM_W     = 8;
   localparam logic [7:0] COMMA_SYM = 8'hBC;

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_LOCKING = 2'd1,
      ST_ALIGNED = 2'd2
   } rx_state_e;

endpackage

// File: rtl/rx_comma_shifter.sv
// Serial-in shift register that presents the window including the current bit (sr_next)
// and flags when that window equals the comma symbol.
module rx_comma_shifter
   import serialtopar_rx_pkg::*;
#(
   parameter int               WIDTH = SYM_W,
   parameter logic [WIDTH-1:0] COMMA = WIDTH'(COMMA_SYM)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             data_i,
   output logic [WIDTH-1:0] sr_next_o,
   output logic             comma_o
);

   // The oldest bit is shifted out on every edge, so only WIDTH-1 bits need storage.
   logic [WIDTH-2:0] sr_q;

   assign sr_next_o = {sr_q, data_i};
   assign comma_o   = (sr_next_o == COMMA);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_next_o[WIDTH-2:0];
      end
   end

endmodule

// File: rtl/serialtopar_rx.sv
// Receive deserializer: locks byte alignment on LOCK_COUNT consecutive commas, then
// emits one symbol per WIDTH clocks with a payload-valid flag and a strobe.
module serialtopar_rx
   import serialtopar_rx_pkg::*;
#(
   parameter int               WIDTH      = SYM_W,
   parameter logic [WIDTH-1:0] COMMA      = WIDTH'(COMMA_SYM),
   parameter int               LOCK_COUNT = 4
) (
   input  logic             clk_8f,
   input  logic             reset,
   input  logic             data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic             byte_strobe,
   output logic             active,
   output rx_state_e        state_dbg_o
);

   localparam int BW = $clog2(WIDTH);
   localparam int CW = $clog2(LOCK_COUNT + 1);

   rx_state_e        state_q, state_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [CW-1:0]    comma_cnt_q, comma_cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             strobe_q, strobe_d;

   logic [WIDTH-1:0] sr_next;
   logic             comma_hit;
   logic             boundary;
   logic [CW-1:0]    comma_inc;
   logic [BW-1:0]    bit_cnt_inc;

   rx_comma_shifter #(
      .WIDTH (WIDTH),
      .COMMA (COMMA)
   ) u_shifter (
      .clk_i     (clk_8f),
      .reset_i   (reset),
      .data_i    (data_in),
      .sr_next_o (sr_next),
      .comma_o   (comma_hit)
   );

   assign boundary    = (bit_cnt_q == BW'(WIDTH - 1));
   assign comma_inc   = comma_cnt_q + CW'(1);
   assign bit_cnt_inc = boundary ? '0 : bit_cnt_q + BW'(1);

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      comma_cnt_d = comma_cnt_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      strobe_d    = 1'b0;

      unique case (state_q)
         ST_SEARCH: begin
            if (comma_hit) begin
               bit_cnt_d   = '0;
               comma_cnt_d = CW'(1);
               state_d     = ST_LOCKING;
            end
         end
         ST_LOCKING: begin
            bit_cnt_d = bit_cnt_inc;
            if (boundary) begin
               if (comma_hit) begin
                  comma_cnt_d = comma_inc;
                  if (comma_inc == CW'(LOCK_COUNT)) begin
                     state_d = ST_ALIGNED;
                  end
               end else begin
                  // Scanning restarts on the next bit; the rejected symbol is not rescanned.
                  comma_cnt_d = '0;
                  bit_cnt_d   = '0;
                  state_d     = ST_SEARCH;
               end
            end
         end
         ST_ALIGNED: begin
            bit_cnt_d = bit_cnt_inc;
            valid_d   = valid_q;
            if (boundary) begin
               data_d   = sr_next;
               valid_d  = !comma_hit;
               strobe_d = 1'b1;
            end
         end
         default: begin
            state_d     = ST_SEARCH;
            bit_cnt_d   = '0;
            comma_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_8f) begin
      if (reset) begin
         state_q     <= ST_SEARCH;
         bit_cnt_q   <= '0;
         comma_cnt_q <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         strobe_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         comma_cnt_q <= comma_cnt_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         strobe_q    <= strobe_d;
      end
   end

   assign data_out    = data_q;
   assign valid_out   = valid_q;
   assign byte_strobe = strobe_q;
   assign active      = (state_q == ST_ALIGNED);
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_serialtopar_rx.sv
// Directed bench for serialtopar_rx: reset, comma lock, payload/idle decode, lock abort,
// mid-payload reset and a TX-style loopback stream checked against an expected queue.
module tb_serialtopar_rx;
   import serialtopar_rx_pkg::*;

   localparam logic [7:0] BC = 8'hBC;

   logic       clk_8f;
   logic       reset;
   logic       data_in;
   logic [7:0] data_out;
   logic       valid_out;
   logic       byte_strobe;
   logic       active;
   rx_state_e  state_dbg;

   int         n_checks;
   int         n_fail;
   logic       rst_drv;
   logic       mon_en;
   int         mon_strobes;
   logic [8:0] exp_q[$];

   serialtopar_rx dut (
      .clk_8f      (clk_8f),
      .reset       (reset),
      .data_in     (data_in),
      .data_out    (data_out),
      .valid_out   (valid_out),
      .byte_strobe (byte_strobe),
      .active      (active),
      .state_dbg_o (state_dbg)
   );

   // clock
   initial clk_8f = 1'b0;
   always #5 clk_8f = ~clk_8f;

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one bit on the falling edge; return 1 time unit after the sampling edge.
   task automatic send_bit(input logic b);
      logic [8:0] e;
      @(negedge clk_8f);
      data_in = b;
      reset   = rst_drv;
      @(posedge clk_8f);
      #1;
      if (mon_en && byte_strobe) begin
         mon_strobes++;
         if (exp_q.size() == 0) begin
            check_eq("extra_strobe", 16'(data_out), 16'hFFFF);
         end else begin
            e = exp_q.pop_front();
            check_eq("loop_data", 16'(data_out), 16'(e[7:0]));
            check_eq("loop_valid", 16'(valid_out), 16'(e[8]));
         end
      end
   endtask

   // Send a symbol MSB first; report strobes seen during its first 7 bits.
   task automatic send_byte(input logic [7:0] b, output int early);
      early = 0;
      for (int i = 7; i >= 0; i--) begin
         send_bit(b[i]);
         if (i > 0 && byte_strobe === 1'b1) early++;
      end
   endtask

   initial begin
      int early;
      int nsym;
      int bval;
      n_checks    = 0;
      n_fail      = 0;
      mon_en      = 1'b0;
      mon_strobes = 0;
      rst_drv     = 1'b1;
      reset       = 1'b1;
      data_in     = 1'b0;

      // 1: reset with random serial data
      for (int i = 0; i < 3; i++) begin
         send_bit(1'($urandom_range(0, 1)));
         check_eq("rst_active", 16'(active), 16'h0);
         check_eq("rst_data", 16'(data_out), 16'h0);
         check_eq("rst_valid", 16'(valid_out), 16'h0);
         check_eq("rst_strobe", 16'(byte_strobe), 16'h0);
      end
      check_eq("rst_state", 16'(state_dbg), 16'(ST_SEARCH));
      rst_drv = 1'b0;

      // 2: junk bits, four commas, then payload 5A
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      check_eq("junk_state", 16'(state_dbg), 16'(ST_SEARCH));
      send_byte(BC, early);
      check_eq("bc1_state", 16'(state_dbg), 16'(ST_LOCKING));
      send_byte(BC, early);
      send_byte(BC, early);
      check_eq("bc3_active", 16'(active), 16'h0);
      for (int i = 7; i >= 1; i--) send_bit(BC[i]);
      check_eq("bc4_pre_active", 16'(active), 16'h0);
      send_bit(BC[0]);
      check_eq("bc4_active", 16'(active), 16'h1);
      check_eq("bc4_strobe", 16'(byte_strobe), 16'h0);
      send_byte(8'h5A, early);
      check_eq("p5a_early", 16'(early), 16'h0);
      check_eq("p5a_strobe", 16'(byte_strobe), 16'h1);
      check_eq("p5a_data", 16'(data_out), 16'h5A);
      check_eq("p5a_valid", 16'(valid_out), 16'h1);

      // 3: idle comma after lock, strobe period 8
      send_byte(BC, early);
      check_eq("idle_early", 16'(early), 16'h0);
      check_eq("idle_strobe", 16'(byte_strobe), 16'h1);
      check_eq("idle_data", 16'(data_out), 16'hBC);
      check_eq("idle_valid", 16'(valid_out), 16'h0);
      send_byte(8'h77, early);
      check_eq("p77_data", 16'(data_out), 16'h77);
      check_eq("p77_valid", 16'(valid_out), 16'h1);
      send_bit(1'b0);
      check_eq("hold_data", 16'(data_out), 16'h77);
      check_eq("hold_valid", 16'(valid_out), 16'h1);
      check_eq("hold_strobe", 16'(byte_strobe), 16'h0);

      // 5: one-clock reset mid-payload drops lock
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      rst_drv = 1'b1;
      send_bit(1'b0);
      rst_drv = 1'b0;
      check_eq("mrst_active", 16'(active), 16'h0);
      check_eq("mrst_valid", 16'(valid_out), 16'h0);
      check_eq("mrst_strobe", 16'(byte_strobe), 16'h0);
      check_eq("mrst_state", 16'(state_dbg), 16'(ST_SEARCH));

      // 4: BC,BC,00 aborts locking; then four commas relock
      send_byte(BC, early);
      send_byte(BC, early);
      check_eq("abort_pre_state", 16'(state_dbg), 16'(ST_LOCKING));
      send_byte(8'h00, early);
      check_eq("abort_state", 16'(state_dbg), 16'(ST_SEARCH));
      check_eq("abort_active", 16'(active), 16'h0);
      send_byte(BC, early);
      send_byte(BC, early);
      send_byte(BC, early);
      check_eq("relock3_active", 16'(active), 16'h0);
      send_byte(BC, early);
      check_eq("relock4_active", 16'(active), 16'h1);

      // 6: loopback stream 01..FF with idle slots interleaved
      mon_en = 1'b1;
      nsym   = 0;
      bval   = 1;
      for (int k = 0; bval <= 255; k++) begin
         if (k % 3 != 2) begin
            exp_q.push_back({(8'(bval) != BC), 8'(bval)});
            send_byte(8'(bval), early);
            bval++;
         end else begin
            exp_q.push_back({1'b0, BC});
            send_byte(BC, early);
         end
         nsym++;
      end
      mon_en = 1'b0;
      check_eq("loop_left", 16'(exp_q.size()), 16'h0);
      check_eq("loop_count", 16'(mon_strobes), 16'(nsym));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
